// File: rtl/led_blink_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_pkg
//
// Shared definitions for the LED blink reporter:
//   - blink_st_t  : report sequencer states
//   - DEF_*       : default phase timing for a 100 MHz clk
//                   (about 84 ms on, 84 ms off, 168 ms closing gap)
//   - cyc_in_range: elaboration-time legality test for a phase length
// -----------------------------------------------------------------------------
package led_blink_pkg;

  // Report sequencer states. S_IDLE must stay the reset/ready state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } blink_st_t;

  // Default timing at 100 MHz.
  localparam int unsigned DEF_CNT_W   = 24;
  localparam int unsigned DEF_ON_CYC  = 2**23;
  localparam int unsigned DEF_OFF_CYC = 2**23;
  localparam int unsigned DEF_GAP_CYC = 2**24 - 1;

  // A phase length is legal when the phase timer can reach length-1 and the
  // phase lasts at least one cycle.
  function automatic bit cyc_in_range(input longint unsigned cyc,
                                      input int unsigned     cnt_w);
    longint unsigned max_cyc;
    max_cyc = (64'd1 << cnt_w) - 64'd1;
    return (cyc >= 64'd1) && (cyc <= max_cyc);
  endfunction

endpackage : led_blink_pkg

// File: rtl/blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
//
// Free-running phase timer for the LED blink reporter. The parent decides when
// a phase ends by comparing count against its own per-phase limit; this block
// only clears and counts.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   clear    in   force count to 0 on the next edge (wins over run)
//   run      in   increment count on the next edge
//   count    out  current phase cycle index, CNT_W bits
// -----------------------------------------------------------------------------
module blink_timer
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : blink_timer

// File: rtl/led_blink_reporter.sv
// -----------------------------------------------------------------------------
// led_blink_reporter
//
// Reports an 8-bit value to an operator by blinking one LED that many times.
// An accepted start latches count; the block then emits count on/off blinks
// (no trailing off phase after the last one), holds a dark gap, pulses done for
// one cycle and returns to ready. A count of 0 produces only the dark gap.
//
// Busy time for count N >= 1 is N*ON_CYC + (N-1)*OFF_CYC + GAP_CYC cycles;
// for N = 0 it is GAP_CYC cycles.
//
// Parameters:
//   CNT_W    width of the phase timer
//   ON_CYC   cycles the LED is lit per blink          (1 .. 2**CNT_W-1)
//   OFF_CYC  cycles the LED is dark between blinks    (1 .. 2**CNT_W-1)
//   GAP_CYC  dark cycles after the last blink         (1 .. 2**CNT_W-1)
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset; abandons a report, no done
//   start    in   request strobe, sampled only while ready = 1
//   count    in   number of blinks, latched on the accepted start
//   ready    out  1 when idle and able to accept start
//   busy     out  ~ready
//   led      out  LED drive, active high
//   done     out  one-cycle pulse in the first idle cycle after a report
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module led_blink_reporter
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned ON_CYC  = DEF_ON_CYC,
  parameter int unsigned OFF_CYC = DEF_OFF_CYC,
  parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] count,
  output logic       ready,
  output logic       busy,
  output logic       led,
  output logic       done
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  if (!cyc_in_range(64'(ON_CYC), CNT_W)) begin : g_bad_on_cyc
    $error("led_blink_reporter: ON_CYC must lie in 1 .. 2**CNT_W-1");
  end
  if (!cyc_in_range(64'(OFF_CYC), CNT_W)) begin : g_bad_off_cyc
    $error("led_blink_reporter: OFF_CYC must lie in 1 .. 2**CNT_W-1");
  end
  if (!cyc_in_range(64'(GAP_CYC), CNT_W)) begin : g_bad_gap_cyc
    $error("led_blink_reporter: GAP_CYC must lie in 1 .. 2**CNT_W-1");
  end

  // Last timer value of each phase; a phase ends on the cycle the timer
  // equals its limit, so it lasts exactly *_CYC cycles.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC  - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  blink_st_t        state_q;
  logic [7:0]       remaining_q;   // blinks still to start, including current
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_last;
  logic             phase_done;
  logic             timer_clear;
  logic             timer_run;

  // ---------------------------------------------------------------------------
  // Phase timer
  //
  // Every state change out of a busy phase coincides with phase_done, and the
  // timer is held at 0 while idle, so clearing on (idle | phase_done) restarts
  // it at 0 on every state change.
  // ---------------------------------------------------------------------------
  assign timer_clear = (state_q == S_IDLE) | phase_done;
  assign timer_run   = (state_q != S_IDLE);

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .run     (timer_run),
    .count   (phase_cnt)
  );

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    phase_last = '0;
    unique case (state_q)
      S_ON:    phase_last = ON_LAST;
      S_OFF:   phase_last = OFF_LAST;
      S_GAP:   phase_last = GAP_LAST;
      default: phase_last = '0;
    endcase
  end

  assign phase_done = (state_q != S_IDLE) && (phase_cnt == phase_last);

  // ---------------------------------------------------------------------------
  // Report sequencer
  //
  // remaining is only decremented when it is >= 2 (an ON phase that is not the
  // last one), so a count of 255 runs 255 blinks without wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'd0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= count;
            state_q     <= (count != 8'd0) ? S_ON : S_GAP;
          end
        end
        S_ON: begin
          if (phase_done) begin
            if (remaining_q == 8'd1) begin
              state_q <= S_GAP;
            end else begin
              state_q     <= S_OFF;
              remaining_q <= remaining_q - 8'd1;
            end
          end
        end
        S_OFF: begin
          if (phase_done) begin
            state_q <= S_ON;
          end
        end
        S_GAP: begin
          // done rises together with the return to idle, so the done cycle is
          // also the first cycle in which a new start is accepted.
          if (phase_done) begin
            state_q <= S_IDLE;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, straight from the state register
  // ---------------------------------------------------------------------------
  assign led   = (state_q == S_ON);
  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;

endmodule : led_blink_reporter
